// File: rtl/spart_bus_arbiter.sv
// spart_bus_arbiter
//   Sole master of the SPART register interface. After reset it programs the
//   baud divisor selected by br_cfg. It then runs one arbitrated single-byte
//   register transaction at a time on behalf of two requesters:
//   r0 (game core) and r1 (host/debug).
//
//   Optional build macro: SPART_ARB_FIXED_PRI_EN
//     defined   -> r0 always wins simultaneous requests (no round-robin pointer)
//     undefined -> round-robin; the requester not granted last wins
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   br_cfg[1:0]         baud select, sampled during the divisor-low init cycle
//   rN_req              request, held until rN_done
//   rN_we               1=write, 0=read
//   rN_addr[1:0]        00 data, 01 status, 10 div low, 11 div high
//   rN_wdata[7:0]       write data
//   rN_gnt              requester owns the bus (WAIT/ACCESS/RESP)
//   rN_done             one-cycle completion pulse
//   rN_rdata[7:0]       read data, valid with done, held until the next done
//   iocs, iorw, ioaddr  SPART chip select, 1=read/0=write, register address
//   rda, tbr            SPART receive-data-available, transmit-buffer-ready
//   databus[7:0]        driven only on write cycles, otherwise high-Z

module spart_bus_arbiter #(
    parameter logic [15:0] DIV_BASE = 16'd10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,

    input  logic       r0_req,
    input  logic       r0_we,
    input  logic [1:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_gnt,
    output logic       r0_done,
    output logic [7:0] r0_rdata,

    input  logic       r1_req,
    input  logic       r1_we,
    input  logic [1:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_gnt,
    output logic       r1_done,
    output logic [7:0] r1_rdata,

    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    input  logic       rda,
    input  logic       tbr,
    inout  wire  [7:0] databus
);

    typedef enum logic [2:0] {
        StInitLo,
        StInitHi,
        StIdle,
        StWait,
        StAccess,
        StResp
    } state_e;

    localparam logic [1:0] AddrData   = 2'b00;
    localparam logic [1:0] AddrStatus = 2'b01;
    localparam logic [1:0] AddrDivLo  = 2'b10;
    localparam logic [1:0] AddrDivHi  = 2'b11;

    state_e      state_q, state_d;
    // Low for the first cycle out of reset so StInitLo never drives the bus
    // while rst is still asserted; the init cycle begins on the first edge.
    logic        armed_q;
    logic        owner_q, owner_d;     // 0 = r0, 1 = r1
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  r0_rdata_q, r1_rdata_q;

    logic [15:0] cfg_div;
    logic        winner;
    logic        any_req;
    logic        illegal;
    logic        ready;
    logic        drive_en;
    logic [7:0]  drive_data;
    logic        busy;

    assign cfg_div = DIV_BASE >> br_cfg;
    assign any_req = r0_req | r1_req;

`ifdef SPART_ARB_FIXED_PRI_EN
    assign winner = ~r0_req;
`else
    logic prefer_r1_q;

    // On a tie the pointer picks; otherwise whoever is requesting wins.
    assign winner = (r0_req && r1_req) ? prefer_r1_q : r1_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_r1_q <= 1'b0;
        end else if (state_q == StIdle && any_req) begin
            prefer_r1_q <= ~winner;
        end
    end
`endif

    // Write to status and reads of the divisor bytes have no bus cycle.
    assign illegal = (we_q && addr_q == AddrStatus) ||
                     (!we_q && (addr_q == AddrDivLo || addr_q == AddrDivHi));

    always_comb begin
        ready = 1'b1;
        if (addr_q == AddrData) begin
            ready = we_q ? tbr : rda;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        div_d      = div_q;
        iocs       = 1'b0;
        iorw       = 1'b0;
        ioaddr     = 2'b00;
        drive_en   = 1'b0;
        drive_data = 8'h00;

        case (state_q)
            StInitLo: begin
                if (armed_q) begin
                    iocs       = 1'b1;
                    ioaddr     = AddrDivLo;
                    drive_en   = 1'b1;
                    drive_data = cfg_div[7:0];
                    div_d      = cfg_div;
                    state_d    = StInitHi;
                end
            end
            StInitHi: begin
                iocs       = 1'b1;
                ioaddr     = AddrDivHi;
                drive_en   = 1'b1;
                drive_data = div_q[15:8];
                state_d    = StIdle;
            end
            StIdle: begin
                if (any_req) begin
                    owner_d = winner;
                    we_d    = winner ? r1_we    : r0_we;
                    addr_d  = winner ? r1_addr  : r0_addr;
                    wdata_d = winner ? r1_wdata : r0_wdata;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (illegal) begin
                    state_d = StResp;
                end else if (ready) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                iocs   = 1'b1;
                iorw   = ~we_q;
                ioaddr = addr_q;
                if (we_q) begin
                    drive_en   = 1'b1;
                    drive_data = wdata_q;
                    // Divisor writes update our shadow so a later reset-free
                    // path never needs br_cfg again.
                    if (addr_q == AddrDivLo) begin
                        div_d[7:0] = wdata_q;
                    end else if (addr_q == AddrDivHi) begin
                        div_d[15:8] = wdata_q;
                    end
                end
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInitLo;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInitLo;
            armed_q <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 2'b00;
            wdata_q <= 8'h00;
            div_q   <= DIV_BASE;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            div_q   <= div_d;
        end
    end

    // Read data is captured at the edge that ends ACCESS; an illegal access
    // returns zero at the edge that moves WAIT to RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_rdata_q <= 8'h00;
            r1_rdata_q <= 8'h00;
        end else if (state_q == StAccess && !we_q) begin
            if (owner_q) begin
                r1_rdata_q <= databus;
            end else begin
                r0_rdata_q <= databus;
            end
        end else if (state_q == StWait && illegal) begin
            if (owner_q) begin
                r1_rdata_q <= 8'h00;
            end else begin
                r0_rdata_q <= 8'h00;
            end
        end
    end

    assign busy     = (state_q == StWait) || (state_q == StAccess) || (state_q == StResp);
    assign r0_gnt   = busy && !owner_q;
    assign r1_gnt   = busy && owner_q;
    assign r0_done  = (state_q == StResp) && !owner_q;
    assign r1_done  = (state_q == StResp) && owner_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;

    assign databus = drive_en ? drive_data : 8'bz;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: init sequence, stalled write, data
// read, arbitration order, illegal access and reset abort.

module tb_spart_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] br_cfg;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [1:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_gnt, r0_done, r1_gnt, r1_done;
    logic [7:0] r0_rdata, r1_rdata;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic       rda, tbr;
    wire  [7:0] databus;
    logic       spart_drive;
    logic [7:0] spart_data;

    int total;
    int bad;

    assign databus = spart_drive ? spart_data : 8'bz;

    spart_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .r0_req   (r0_req),
        .r0_we    (r0_we),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_gnt   (r0_gnt),
        .r0_done  (r0_done),
        .r0_rdata (r0_rdata),
        .r1_req   (r1_req),
        .r1_we    (r1_we),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_gnt   (r1_gnt),
        .r1_done  (r1_done),
        .r1_rdata (r1_rdata),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .rda      (rda),
        .tbr      (tbr),
        .databus  (databus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic exp_win;
        total = 0;
        bad = 0;
        rst = 1'b1;
        br_cfg = 2'b10;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        rda = 0; tbr = 0; spart_drive = 0; spart_data = 0;

        tick(); tick();
        chk("rst_iocs", iocs, 0);
        chk("rst_gnt", {r0_gnt, r1_gnt}, 0);
        chk("rst_done", {r0_done, r1_done}, 0);
        chk("rst_rdata", {r0_rdata, r1_rdata}, 0);

        // Init with br_cfg=10: divisor 2604 = 0x0A2C.
        rst = 1'b0;
        tick();
        chk("init_lo_iocs", iocs, 1);
        chk("init_lo_addr", ioaddr, 2'b10);
        chk("init_lo_rw", iorw, 0);
        chk("init_lo_data", databus, 8'h2C);
        tick();
        chk("init_hi_addr", ioaddr, 2'b11);
        chk("init_hi_data", databus, 8'h0A);
        tick();
        chk("idle_iocs", iocs, 0);

        // r0 write data 0x41, stalled on tbr for 5 cycles.
        r0_req = 1; r0_we = 1; r0_addr = 2'b00; r0_wdata = 8'h41;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_gnt", {r0_gnt, r1_gnt}, 2'b10);
            chk("stall_iocs", iocs, 0);
            chk("stall_done", r0_done, 0);
        end
        tbr = 1;
        tick();
        chk("wr_iocs", iocs, 1);
        chk("wr_iorw", iorw, 0);
        chk("wr_addr", ioaddr, 2'b00);
        chk("wr_data", databus, 8'h41);
        chk("wr_done_early", r0_done, 0);
        tick();
        chk("wr_done", {r0_done, r1_done}, 2'b10);
        chk("wr_resp_iocs", iocs, 0);
        r0_req = 0; tbr = 0;
        tick();
        chk("wr_done_once", r0_done, 0);
        chk("wr_gnt_drop", {r0_gnt, r1_gnt}, 0);

        // r1 read data with SPART returning 0x5A.
        r1_req = 1; r1_we = 0; r1_addr = 2'b00; rda = 1;
        spart_drive = 1; spart_data = 8'h5A;
        tick();
        chk("rd_gnt", {r0_gnt, r1_gnt}, 2'b01);
        tick();
        chk("rd_iocs", iocs, 1);
        chk("rd_iorw", iorw, 1);
        chk("rd_bus", databus, 8'h5A);
        tick();
        chk("rd_done", {r0_done, r1_done}, 2'b01);
        chk("rd_rdata", r1_rdata, 8'h5A);
        r1_req = 0; rda = 0; spart_drive = 0;
        tick();

        // Both request status reads continuously.
        r0_req = 1; r0_we = 0; r0_addr = 2'b01;
        r1_req = 1; r1_we = 0; r1_addr = 2'b01;
        for (int i = 0; i < 4; i++) begin
`ifdef SPART_ARB_FIXED_PRI_EN
            exp_win = 1'b0;
`else
            exp_win = (i % 2 == 1);
`endif
            tick();
            chk("arb_gnt", {r0_gnt, r1_gnt}, exp_win ? 2'b01 : 2'b10);
            tick();
            chk("arb_access", {iocs, iorw, ioaddr}, 4'b1101);
            tick();
            chk("arb_done", {r0_done, r1_done}, exp_win ? 2'b01 : 2'b10);
            if (i == 3) begin
                r0_req = 0; r1_req = 0;
            end
            tick();
        end

        // r0 write to status: illegal, no bus cycle, rdata forced to zero.
        r0_req = 1; r0_we = 1; r0_addr = 2'b01; r0_wdata = 8'hFF;
        tick();
        chk("ill_gnt", r0_gnt, 1);
        chk("ill_wait_iocs", iocs, 0);
        tick();
        chk("ill_done", {r0_done, r1_done}, 2'b10);
        chk("ill_iocs", iocs, 0);
        chk("ill_rdata", r0_rdata, 8'h00);
        r0_req = 0;
        tick();

        // Reset during a WAIT stall; init reruns with br_cfg=01 (0x1458).
        r1_req = 1; r1_we = 1; r1_addr = 2'b00; r1_wdata = 8'h77; tbr = 0;
        tick();
        tick();
        chk("abort_pre_gnt", r1_gnt, 1);
        rst = 1;
        #1;
        chk("abort_gnt", {r0_gnt, r1_gnt}, 0);
        chk("abort_done", {r0_done, r1_done}, 0);
        chk("abort_iocs", iocs, 0);
        r1_req = 0; br_cfg = 2'b01;
        tick();
        chk("abort_hold_done", r1_done, 0);
        rst = 0;
        tick();
        chk("reinit_lo", {iocs, ioaddr}, 3'b110);
        chk("reinit_lo_data", databus, 8'h58);
        tick();
        chk("reinit_hi", {iocs, ioaddr}, 3'b111);
        chk("reinit_hi_data", databus, 8'h14);
        tick();
        chk("reinit_idle", {iocs, r0_done, r1_done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
